// File: rtl/taylor_term_accumulator.sv
// Power-series accumulator: sums c[k]*x^k in signed Q(DATA_W-FRAC_W).FRAC_W fixed point.
// Define TAYLOR_ACC_SAT_EN for a saturating accumulator with a sticky overflow flag.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; accept latches x, resets acc and pow
// LAUNCH | single-cycle start_cntr pulse to the term counter
// RUN    | terms streaming in; done raised with the last index read
// DRAIN  | last coefficient returns from the ROM and is accumulated
// DONE   | result_valid pulse, result holds the final sum

module taylor_term_accumulator #(
   parameter int DATA_W     = 32,
   parameter int FRAC_W     = 16,
   parameter int CNTR_DEPTH = 5,
   parameter int NUM_TERMS  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_W-1:0]     x_in,
   input  logic                  coeff_rd_en,
   input  logic [CNTR_DEPTH-1:0] term_cnt,
   input  logic [DATA_W-1:0]     coeff_in,
   output logic                  start_cntr,
   output logic                  done,
   output logic                  busy,
   output logic [DATA_W-1:0]     result,
   output logic                  result_valid,
   output logic                  overflow
);

   localparam int                    PROD_W   = 2 * DATA_W;
   localparam logic [CNTR_DEPTH-1:0] LAST_IDX = CNTR_DEPTH'(NUM_TERMS - 1);
   localparam logic [DATA_W-1:0]     POW_ONE  = DATA_W'(1) << FRAC_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [DATA_W-1:0] r_x;
   logic [DATA_W-1:0] r_acc;
   logic [DATA_W-1:0] r_pow;
   logic [DATA_W-1:0] r_result;
   logic              r_rd_en_d;
   logic              r_start_cntr;
   logic              r_result_valid;

   logic              w_done;
   logic              w_accept;
   logic              w_acc_en;
   logic [DATA_W-1:0] w_prod;
   logic [DATA_W-1:0] w_pow_nxt;
   logic [DATA_W-1:0] w_acc_sum;
   logic [DATA_W-1:0] w_acc_upd;

   logic signed [PROD_W-1:0] w_coeff_ext;
   logic signed [PROD_W-1:0] w_pow_ext;
   logic signed [PROD_W-1:0] w_x_ext;
   logic signed [PROD_W-1:0] w_prod_full;
   logic signed [PROD_W-1:0] w_pow_full;
   logic                     w_unused_bits;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            w_state_nxt = S_RUN;
         end
         S_RUN: begin
            // combinational so the counter stops without issuing an extra read
            if (coeff_rd_en && (term_cnt == LAST_IDX)) begin
               w_done      = 1'b1;
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_accept = (r_state == S_IDLE) && start;
   assign w_acc_en = r_rd_en_d && ((r_state == S_RUN) || (r_state == S_DRAIN));

   // ---------------- arithmetic ----------------
   assign w_coeff_ext = {{DATA_W{coeff_in[DATA_W-1]}}, coeff_in};
   assign w_pow_ext   = {{DATA_W{r_pow[DATA_W-1]}}, r_pow};
   assign w_x_ext     = {{DATA_W{r_x[DATA_W-1]}}, r_x};
   assign w_prod_full = w_coeff_ext * w_pow_ext;
   assign w_pow_full  = w_pow_ext * w_x_ext;

   // slicing above FRAC_W is the arithmetic shift; floor rounding, no correction
   assign w_prod    = w_prod_full[FRAC_W +: DATA_W];
   assign w_pow_nxt = w_pow_full[FRAC_W +: DATA_W];

   assign w_unused_bits = ^{w_prod_full[FRAC_W-1:0], w_prod_full[PROD_W-1:FRAC_W+DATA_W],
                            w_pow_full[FRAC_W-1:0],  w_pow_full[PROD_W-1:FRAC_W+DATA_W]};

`ifdef TAYLOR_ACC_SAT_EN
   localparam logic [DATA_W-1:0] ACC_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] ACC_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   logic [DATA_W:0] w_sum_ext;
   logic            w_sum_ovf;
   logic            r_overflow;

   assign w_sum_ext = {r_acc[DATA_W-1], r_acc} + {w_prod[DATA_W-1], w_prod};
   assign w_sum_ovf = w_sum_ext[DATA_W] ^ w_sum_ext[DATA_W-1];
   assign w_acc_sum = !w_sum_ovf         ? w_sum_ext[DATA_W-1:0] :
                      w_sum_ext[DATA_W]  ? ACC_MIN : ACC_MAX;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
      end else if (w_accept) begin
         r_overflow <= 1'b0;
      end else if (w_acc_en && w_sum_ovf) begin
         r_overflow <= 1'b1;
      end
   end

   assign overflow = r_overflow;
`else
   assign w_acc_sum = r_acc + w_prod;
   assign overflow  = 1'b0;
`endif

   assign w_acc_upd = w_acc_en ? w_acc_sum : r_acc;

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_x            <= '0;
         r_acc          <= '0;
         r_pow          <= POW_ONE;
         r_result       <= '0;
         r_rd_en_d      <= 1'b0;
         r_start_cntr   <= 1'b0;
         r_result_valid <= 1'b0;
      end else begin
         r_rd_en_d      <= coeff_rd_en;
         r_start_cntr   <= w_accept;
         r_result_valid <= (r_state == S_DRAIN);
         if (w_accept) begin
            r_x   <= x_in;
            r_acc <= '0;
            r_pow <= POW_ONE;
         end else if (w_acc_en) begin
            r_acc <= w_acc_sum;
            r_pow <= w_pow_nxt;
         end
         // capture the sum including the term arriving in DRAIN
         if (r_state == S_DRAIN) begin
            r_result <= w_acc_upd;
         end
      end
   end

   assign start_cntr   = r_start_cntr;
   assign done         = w_done;
   assign busy         = (r_state != S_IDLE);
   assign result       = r_result;
   assign result_valid = r_result_valid;

endmodule
